// File: rtl/window_scan_feeder.sv
// Serpentine source sequencer for a 7x7 window buffer: fetches one 7-pixel column or row
// per step from a synchronous image RAM, shifts it into the buffer and presents each full window.
module window_scan_feeder #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        buffer_input [0:6],
  output logic              shift_enable,
  output logic [1:0]        shift_direction,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [7:0]        win_x,
  output logic [7:0]        win_y
);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SHIFT, PRESENT, DONE} state_e;
  typedef enum logic [1:0] {STEP_FILL, STEP_RIGHT, STEP_DOWN, STEP_LEFT} step_e;

  localparam logic [7:0] XLAST = 8'(IMG_W - 7);
  localparam logic [7:0] YLAST = 8'(IMG_H - 7);

  state_e            state_q;
  step_e             step_q;
  logic [2:0]        k_q;
  logic [2:0]        fill_q;
  logic              rd_valid_q;
  logic [2:0]        rd_idx_q;
  logic [7:0]        x0_q;
  logic [7:0]        y0_q;
  logic              dir_right_q;
  logic              busy_q;
  logic              done_q;
  logic              mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              shift_en_q;
  logic [1:0]        shift_dir_q;
  logic              win_valid_q;
  logic [7:0]        pix_q [0:6];

  step_e             next_step_d;
  logic              at_edge_d;
  logic              last_win_d;

  // Address of read k for a step, taken before the window origin moves.
  function automatic logic [ADDR_W-1:0] addrOf(step_e s, logic [2:0] k, logic [2:0] col,
                                               logic [7:0] x0, logic [7:0] y0);
    logic [31:0] x;
    logic [31:0] y;
    x = 32'(x0);
    y = 32'(y0);
    case (s)
      STEP_FILL:  begin x = 32'(col);      y = 32'(k);      end
      STEP_RIGHT: begin x = x + 32'd7;     y = y + 32'(k);  end
      STEP_LEFT:  begin x = x - 32'd1;     y = y + 32'(k);  end
      default:    begin x = x + 32'(k);    y = y + 32'd7;   end
    endcase
    return ADDR_W'(y * 32'(IMG_W) + x);
  endfunction

  function automatic logic [1:0] dirCode(step_e s);
    case (s)
      STEP_DOWN: return 2'b11;
      STEP_LEFT: return 2'b10;
      default:   return 2'b01;
    endcase
  endfunction

  always_comb begin
    at_edge_d   = (x0_q == (dir_right_q ? XLAST : 8'd0));
    last_win_d  = at_edge_d && (y0_q == YLAST);
    next_step_d = at_edge_d ? STEP_DOWN : (dir_right_q ? STEP_RIGHT : STEP_LEFT);
  end

  // Read data lands one cycle after issue, so the slot index trails the read strobe by a cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      step_q      <= STEP_FILL;
      k_q         <= '0;
      fill_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_idx_q    <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      dir_right_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      shift_en_q  <= 1'b0;
      shift_dir_q <= 2'b00;
      win_valid_q <= 1'b0;
      for (int i = 0; i < 7; i++) pix_q[i] <= '0;
    end else begin
      done_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      shift_en_q  <= 1'b0;
      shift_dir_q <= 2'b00;
      rd_valid_q  <= mem_rd_q;
      rd_idx_q    <= k_q;
      if (rd_valid_q) pix_q[rd_idx_q] <= mem_rdata;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= FETCH;
            busy_q      <= 1'b1;
            step_q      <= STEP_FILL;
            fill_q      <= '0;
            k_q         <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            dir_right_q <= 1'b1;
            mem_rd_q    <= 1'b1;
            mem_addr_q  <= addrOf(STEP_FILL, 3'd0, 3'd0, 8'd0, 8'd0);
          end
        end
        FETCH: begin
          if (k_q == 3'd6) begin
            state_q <= CAPTURE;
          end else begin
            k_q        <= k_q + 3'd1;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= addrOf(step_q, k_q + 3'd1, fill_q, x0_q, y0_q);
          end
        end
        CAPTURE: begin
          state_q     <= SHIFT;
          shift_en_q  <= 1'b1;
          shift_dir_q <= dirCode(step_q);
        end
        SHIFT: begin
          case (step_q)
            STEP_RIGHT: x0_q <= x0_q + 8'd1;
            STEP_LEFT:  x0_q <= x0_q - 8'd1;
            STEP_DOWN: begin
              y0_q        <= y0_q + 8'd1;
              dir_right_q <= ~dir_right_q;
            end
            default: ;
          endcase
          // The initial fill keeps the origin at (0,0) and only presents after the seventh column.
          if (step_q == STEP_FILL && fill_q != 3'd6) begin
            fill_q     <= fill_q + 3'd1;
            k_q        <= '0;
            state_q    <= FETCH;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= addrOf(STEP_FILL, 3'd0, fill_q + 3'd1, x0_q, y0_q);
          end else begin
            state_q     <= PRESENT;
            win_valid_q <= 1'b1;
          end
        end
        PRESENT: begin
          if (win_ready) begin
            win_valid_q <= 1'b0;
            if (last_win_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              step_q     <= next_step_d;
              k_q        <= '0;
              state_q    <= FETCH;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= addrOf(next_step_d, 3'd0, fill_q, x0_q, y0_q);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign mem_rd          = mem_rd_q;
  assign mem_addr        = mem_addr_q;
  assign buffer_input    = pix_q;
  assign shift_enable    = shift_en_q;
  assign shift_direction = shift_dir_q;
  assign win_valid       = win_valid_q;
  assign win_x           = x0_q;
  assign win_y           = y0_q;

endmodule

// File: tb/tb_window_scan_feeder.sv
// Directed bench for window_scan_feeder: a 9x8 image (RAM[a]=a) for timing, serpentine order,
// back-pressure and abort, plus a 7x7 instance for the single-window case.
module tb_window_scan_feeder;

  localparam int W = 9;
  localparam int H = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       n_rst;
  logic       start;
  logic       win_ready;
  logic       busy, done, mem_rd, shift_enable, win_valid;
  logic [11:0] mem_addr;
  logic [7:0] mem_rdata = 8'd0;
  logic [7:0] buffer_input [0:6];
  logic [1:0] shift_direction;
  logic [7:0] win_x, win_y;

  logic       start7;
  logic       ready7;
  logic       busy7, done7, mem_rd7, shift_enable7, win_valid7;
  logic [11:0] mem_addr7;
  logic [7:0] mem_rdata7 = 8'd0;
  logic [7:0] buffer_input7 [0:6];
  logic [1:0] shift_direction7;
  logic [7:0] win_x7, win_y7;

  window_scan_feeder #(.IMG_W(W), .IMG_H(H), .ADDR_W(12)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .buffer_input(buffer_input), .shift_enable(shift_enable),
    .shift_direction(shift_direction), .win_valid(win_valid), .win_ready(win_ready),
    .win_x(win_x), .win_y(win_y)
  );

  window_scan_feeder #(.IMG_W(7), .IMG_H(7), .ADDR_W(12)) dut7 (
    .clk(clk), .n_rst(n_rst), .start(start7), .busy(busy7), .done(done7),
    .mem_rd(mem_rd7), .mem_addr(mem_addr7), .mem_rdata(mem_rdata7),
    .buffer_input(buffer_input7), .shift_enable(shift_enable7),
    .shift_direction(shift_direction7), .win_valid(win_valid7), .win_ready(ready7),
    .win_x(win_x7), .win_y(win_y7)
  );

  // Synchronous image RAMs holding RAM[a] = a.
  always @(posedge clk) begin
    if (mem_rd)  mem_rdata  <= mem_addr[7:0];
    if (mem_rd7) mem_rdata7 <= mem_addr7[7:0];
  end

  // Pixel k of the column or row fetched to reach window origin (x,y); dir uses shift_direction codes.
  function automatic int expPix(int dir, int x, int y, int k);
    if (dir == 1) return (y + k) * W + x + 6;
    if (dir == 2) return (y + k) * W + x;
    return (y + 6) * W + x + k;
  endfunction

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    start = 1'b0;
    win_ready = 1'b0;
    start7 = 1'b0;
    ready7 = 1'b0;
    #2 n_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 start = 1'($urandom);
      win_ready = 1'($urandom);
      @(negedge clk);
      total++;
      if ({busy, done, mem_rd, shift_enable, win_valid} !== 5'b0) begin
        bad++;
        $display("FAIL reset_ctrl: got %b want 00000", {busy, done, mem_rd, shift_enable, win_valid});
      end
      total++;
      if ({mem_addr, shift_direction, win_x, win_y} !== 30'd0) begin
        bad++;
        $display("FAIL reset_data: addr=%0h dir=%b x=%0d y=%0d want all 0", mem_addr, shift_direction, win_x, win_y);
      end
      for (int k = 0; k < 7; k++) begin
        total++;
        if (buffer_input[k] !== 8'd0) begin
          bad++;
          $display("FAIL reset_buf[%0d]: got %0h want 0", k, buffer_input[k]);
        end
      end
    end
    start = 1'b0;
    win_ready = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({busy, mem_rd} !== 2'b00) begin
        bad++;
        $display("FAIL idle_after_reset: busy,mem_rd got %b want 00", {busy, mem_rd});
      end
    end
  endtask

  task automatic test_fill_timing();
    int shifts;
    logic expRd, expSh;
    shifts = 0;
    win_ready = 1'b0;
    pulseStart();
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      expRd = (c <= 63) && (((c - 1) % 9) < 7);
      expSh = (c <= 63) && ((c % 9) == 0);
      if (shift_enable === 1'b1) shifts++;
      total++;
      if (mem_rd !== expRd) begin
        bad++;
        $display("FAIL fill_rd c%0d: got %b want %b", c, mem_rd, expRd);
      end
      if (expRd) begin
        total++;
        if (mem_addr !== 12'(((c - 1) % 9) * W + (c - 1) / 9)) begin
          bad++;
          $display("FAIL fill_addr c%0d: got %0d want %0d", c, mem_addr, ((c - 1) % 9) * W + (c - 1) / 9);
        end
      end
      total++;
      if (shift_enable !== expSh || shift_direction !== (expSh ? 2'b01 : 2'b00)) begin
        bad++;
        $display("FAIL fill_shift c%0d: got en=%b dir=%b want en=%b", c, shift_enable, shift_direction, expSh);
      end
      total++;
      if (win_valid !== (c == 64)) begin
        bad++;
        $display("FAIL fill_valid c%0d: got %b want %b", c, win_valid, (c == 64));
      end
      if (c >= 63) begin
        for (int k = 0; k < 7; k++) begin
          total++;
          if (buffer_input[k] !== 8'(k * W + 6)) begin
            bad++;
            $display("FAIL fill_buf c%0d[%0d]: got %0d want %0d", c, k, buffer_input[k], k * W + 6);
          end
        end
      end
    end
    total++;
    if (shifts != 7) begin
      bad++;
      $display("FAIL fill_shift_count: got %0d want 7", shifts);
    end
    total++;
    if ({win_x, win_y, busy} !== {8'd0, 8'd0, 1'b1}) begin
      bad++;
      $display("FAIL first_window: x=%0d y=%0d busy=%b want 0 0 1", win_x, win_y, busy);
    end
    win_ready = 1'b1;
  endtask

  // Entered just after the negedge of the previous handshake cycle.
  task automatic waitWindow(input int ex, input int ey, input int dir, input int hold);
    if (hold > 0) begin
      @(posedge clk);
      #1 win_ready = 1'b0;
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      total++;
      if (mem_rd !== (c <= 7)) begin
        bad++;
        $display("FAIL win(%0d,%0d)_rd c%0d: got %b want %b", ex, ey, c, mem_rd, (c <= 7));
      end
      if (c <= 7) begin
        total++;
        if (mem_addr !== 12'(expPix(dir, ex, ey, c - 1))) begin
          bad++;
          $display("FAIL win(%0d,%0d)_addr c%0d: got %0d want %0d", ex, ey, c, mem_addr, expPix(dir, ex, ey, c - 1));
        end
      end
      total++;
      if (shift_enable !== (c == 9) || shift_direction !== (c == 9 ? 2'(dir) : 2'b00)) begin
        bad++;
        $display("FAIL win(%0d,%0d)_shift c%0d: got en=%b dir=%b want dir=%0d", ex, ey, c, shift_enable, shift_direction, dir);
      end
      total++;
      if (win_valid !== (c == 10)) begin
        bad++;
        $display("FAIL win(%0d,%0d)_valid c%0d: got %b want %b", ex, ey, c, win_valid, (c == 10));
      end
      if (c >= 9) begin
        for (int k = 0; k < 7; k++) begin
          total++;
          if (buffer_input[k] !== 8'(expPix(dir, ex, ey, k))) begin
            bad++;
            $display("FAIL win(%0d,%0d)_buf[%0d]: got %0d want %0d", ex, ey, k, buffer_input[k], expPix(dir, ex, ey, k));
          end
        end
      end
      if (c == 10) begin
        total++;
        if (win_x !== 8'(ex) || win_y !== 8'(ey)) begin
          bad++;
          $display("FAIL win_origin: got (%0d,%0d) want (%0d,%0d)", win_x, win_y, ex, ey);
        end
      end
    end
    for (int j = 0; j < hold; j++) begin
      @(negedge clk);
      total++;
      if ({win_valid, mem_rd, shift_enable} !== 3'b100 || win_x !== 8'(ex) || win_y !== 8'(ey)) begin
        bad++;
        $display("FAIL backpressure j%0d: valid,rd,sh=%b x=%0d y=%0d want 100 %0d %0d", j,
                 {win_valid, mem_rd, shift_enable}, win_x, win_y, ex, ey);
      end
      for (int k = 0; k < 7; k++) begin
        total++;
        if (buffer_input[k] !== 8'(expPix(dir, ex, ey, k))) begin
          bad++;
          $display("FAIL backpressure_buf j%0d[%0d]: got %0d want %0d", j, k, buffer_input[k], expPix(dir, ex, ey, k));
        end
      end
    end
    win_ready = 1'b1;
  endtask

  task automatic test_serpentine();
    waitWindow(1, 0, 1, 20);
    waitWindow(2, 0, 1, 0);
    waitWindow(2, 1, 3, 0);
    waitWindow(1, 1, 2, 0);
    waitWindow(0, 1, 2, 0);
    @(negedge clk);
    total++;
    if ({done, busy, win_valid} !== 3'b100) begin
      bad++;
      $display("FAIL scan_done: done,busy,valid got %b want 100", {done, busy, win_valid});
    end
    @(negedge clk);
    total++;
    if ({done, busy, win_valid, mem_rd} !== 4'b0000) begin
      bad++;
      $display("FAIL after_done: done,busy,valid,rd got %b want 0000", {done, busy, win_valid, mem_rd});
    end
  endtask

  task automatic test_min_image();
    int shifts;
    shifts = 0;
    ready7 = 1'b1;
    @(negedge clk);
    start7 = 1'b1;
    @(posedge clk);
    #1 start7 = 1'b0;
    for (int c = 1; c <= 66; c++) begin
      @(negedge clk);
      if (shift_enable7 === 1'b1) shifts++;
      total++;
      if (shift_enable7 !== (c <= 63 && (c % 9) == 0) ||
          (shift_enable7 === 1'b1 && shift_direction7 !== 2'b01)) begin
        bad++;
        $display("FAIL min_shift c%0d: got en=%b dir=%b", c, shift_enable7, shift_direction7);
      end
      total++;
      if ({win_valid7, done7, busy7} !== {(c == 64), (c == 65), (c <= 64)}) begin
        bad++;
        $display("FAIL min_ctrl c%0d: valid,done,busy got %b want %b", c, {win_valid7, done7, busy7},
                 {(c == 64), (c == 65), (c <= 64)});
      end
      if (c == 64) begin
        total++;
        if (win_x7 !== 8'd0 || win_y7 !== 8'd0) begin
          bad++;
          $display("FAIL min_origin: got (%0d,%0d) want (0,0)", win_x7, win_y7);
        end
        for (int k = 0; k < 7; k++) begin
          total++;
          if (buffer_input7[k] !== 8'(k * 7 + 6)) begin
            bad++;
            $display("FAIL min_buf[%0d]: got %0d want %0d", k, buffer_input7[k], k * 7 + 6);
          end
        end
      end
    end
    total++;
    if (shifts != 7) begin
      bad++;
      $display("FAIL min_shift_count: got %0d want 7", shifts);
    end
  endtask

  task automatic test_abort_restart();
    logic expRd;
    win_ready = 1'b1;
    pulseStart();
    for (int c = 1; c <= 77; c++) @(negedge clk);
    total++;
    if (mem_rd !== 1'b1 || mem_addr !== 12'd26) begin
      bad++;
      $display("FAIL abort_pre: rd=%b addr=%0d want 1 26", mem_rd, mem_addr);
    end
    #1 n_rst = 1'b0;
    #1;
    total++;
    if ({busy, done, mem_rd, shift_enable, win_valid, shift_direction} !== 7'd0 ||
        {mem_addr, win_x, win_y} !== 28'd0) begin
      bad++;
      $display("FAIL abort_clear: ctrl=%b addr=%0d x=%0d y=%0d want all 0",
               {busy, done, mem_rd, shift_enable, win_valid, shift_direction}, mem_addr, win_x, win_y);
    end
    for (int k = 0; k < 7; k++) begin
      total++;
      if (buffer_input[k] !== 8'd0) begin
        bad++;
        $display("FAIL abort_buf[%0d]: got %0d want 0", k, buffer_input[k]);
      end
    end
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    pulseStart();
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      expRd = (((c - 1) % 9) < 7);
      total++;
      if (mem_rd !== expRd || (expRd && mem_addr !== 12'(((c - 1) % 9) * W + (c - 1) / 9))) begin
        bad++;
        $display("FAIL restart c%0d: rd=%b addr=%0d want rd=%b addr=%0d", c, mem_rd, mem_addr, expRd,
                 ((c - 1) % 9) * W + (c - 1) / 9);
      end
      if (c == 3) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_busy: got %b want 1", busy);
    end
  endtask

  initial begin
    test_reset();
    test_fill_timing();
    test_serpentine();
    test_min_image();
    test_abort_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_scan_feeder.md
Name: window_scan_feeder

Overview:
- Source-side sequencer for the 7x7 pixel window buffer.
- Walks the window over a stored image in a serpentine scan:
  - reads the needed pixels from a synchronous image RAM;
  - presents them as a 7-pixel vector;
  - drives shift_enable and shift_direction to the window buffer;
  - flags each completed window to the downstream operator (Gaussian/Sobel stage) with a valid/ready handshake.

Parameters:
IMG_W, 64, image width in pixels (>=7)
IMG_H, 64, image height in pixels (>=7)
ADDR_W, 12, image RAM address width (must cover IMG_W*IMG_H-1)

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
start  input  1  begin a scan; accepted only in IDLE
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse after the final window handshake
mem_rd  output  1  RAM read strobe
mem_addr  output  ADDR_W  RAM address = y*IMG_W + x
mem_rdata  input  8  RAM data, valid exactly one cycle after mem_rd
buffer_input  output  8 x [0:6]  unpacked pixel vector to the window buffer
shift_enable  output  1  one-cycle shift strobe
shift_direction  output  2  00 none, 01 right, 11 down, 10 left
win_valid  output  1  window buffer holds a complete new window
win_ready  input  1  downstream accepts the window
win_x  output  8  top-left x of the presented window
win_y  output  8  top-left y of the presented window

Behaviour:
- Reset: all outputs 0, buffer_input all 0, state IDLE, x0=y0=0, dir_right=1.
- States:
  - IDLE: on start, go to FETCH and set busy=1.
  - FETCH: 7 cycles, index k=0..6. mem_rd=1 each cycle with the address below.
  - CAPTURE: 1 cycle. Registers the last read.
  - SHIFT: 1 cycle. shift_enable=1 and shift_direction set for the step.
  - PRESENT: win_valid=1 until win_ready.
  - DONE: 1 cycle. done=1, busy=0, then IDLE.
- Read data: the data for read k is registered into buffer_input[k] the cycle after issue. buffer_input is held stable through SHIFT.
- Fetch addressing by step type:
  - Initial fill: 7 right shifts. Column c=0..6; read k = (x=c, y=k).
  - Right: column x0+7, read k = (x0+7, y0+k). Then x0++.
  - Left: column x0-1, read k = (x0-1, y0+k). Then x0--.
  - Down: row y0+7, read k = (x0+k, y0+7). Then y0++ and dir_right toggles.
- Fill sequencing: after fill shifts 1..6, go straight back to FETCH with no PRESENT. After fill shift 7, go to PRESENT with win_x=0, win_y=0.
- Next-step selection on each PRESENT handshake (win_valid&win_ready):
  - Last window: x0 == (dir_right ? IMG_W-7 : 0) and y0 == IMG_H-7. Go to DONE.
  - Horizontal edge reached: next step is down.
  - Otherwise: next step is right if dir_right, else left.
- Window position: win_x/win_y hold x0/y0 after the update. They are stable while win_valid=1.
- Latency:
  - start accepted at edge 0: fill shift n has shift_enable in cycle 9n, and the first win_valid is in cycle 64.
  - Each later window: win_valid rises 10 cycles after the previous handshake cycle.
- Back-pressure: win_valid stays high and nothing else changes while win_ready=0. No RAM reads are issued during PRESENT.
- Zero-wait handshake: win_ready may already be high when win_valid rises. The handshake then completes in that cycle.
- Window count: total windows = (IMG_W-6)*(IMG_H-6). For IMG_W=IMG_H=7 there is a single window, then DONE.
- start while busy: ignored.
- shift_direction outside SHIFT: 00.
- Reset mid-scan: immediate return to reset values. No shift_enable or mem_rd glitch after n_rst falls.

Test Plan:
- Reset check: hold n_rst=0 with random inputs -> all outputs 0. Release, idle 5 cycles -> busy=0, mem_rd=0.
- Fill and timing (IMG_W=9, IMG_H=8, RAM[a]=a):
  - start -> mem_addr sequence for fill column 0 is 0,9,18,...,54;
  - 7 shift_enable pulses in cycles 9..63, all with direction 01;
  - win_valid in cycle 64 with (win_x,win_y)=(0,0).
- Serpentine order (same image, win_ready=1):
  - window origins in order: (0,0),(1,0),(2,0),(2,1),(1,1),(0,1);
  - post-fill directions in order: 01,01,11,10,10;
  - down-step buffer_input = 65..71;
  - 6 windows total, then a done pulse and busy=0.
- Back-pressure: hold win_ready=0 for 20 cycles on window 2 -> win_valid, win_x, win_y and buffer_input remain stable, with no mem_rd and no shift_enable.
- Minimum image (IMG_W=IMG_H=7): start -> exactly 7 right shifts, one window at (0,0), then done.
- Abort and restart: assert n_rst during the FETCH of window 3 -> outputs cleared the same cycle. A new start then reproduces the fill address sequence from address 0; a start pulse sent while busy has no effect.
